// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: debounced switch commands, saturating credit, 7-segment readout.
// Optional macro VEND_CHANGE_EN: a successful vend returns the excess on CHANGE and zeroes credit.
module vend_credit_ctrl #(
  parameter int STEP        = 4,
  parameter int MAX_UNITS   = 5,
  parameter int PRICE_UNITS = 3,
  parameter int TICK_DIV    = 22,
  parameter int DISP_TICKS  = 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [4:0] SW,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX3,
  output logic [2:0] LEDR,
  output logic [7:0] CHANGE
);

  localparam int CW = $clog2(MAX_UNITS + 1);
  localparam int DW = $clog2(DISP_TICKS + 1);

  localparam logic [CW-1:0] MAX_C   = CW'(MAX_UNITS);
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE_UNITS);
  localparam logic [DW-1:0] DISP_LAST = DW'(DISP_TICKS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HOLD     = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;

  localparam logic [4:0] CMD_ADD1   = 5'b00001;
  localparam logic [4:0] CMD_ADD2   = 5'b00010;
  localparam logic [4:0] CMD_REFUND = 5'b00100;
  localparam logic [4:0] CMD_VEND   = 5'b01000;
  localparam logic [4:0] CMD_CLEAR  = 5'b10000;

  logic [TICK_DIV-1:0] tick_cnt;
  logic                tick;

  logic [4:0] sw_meta;
  logic [4:0] sw_sync;
  logic [4:0] last_sw;
  logic       last_valid;
  logic       sw_valid;
  logic       match;
  logic       accept;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [CW-1:0] credit;
  logic [CW-1:0] credit_next;
  logic          reject;
  logic          reject_next;
  logic [DW-1:0] disp_cnt;
  logic [DW-1:0] disp_next;

  logic [CW+1:0] sum1;
  logic [CW+1:0] sum2;

`ifdef VEND_CHANGE_EN
  logic [7:0] change;
  logic [7:0] change_next;
`endif

  // Free-running divider; tick is a one-cycle enable, never a clock.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = &tick_cnt;

  // Switches are asynchronous to the clock, so bring them in through two flops.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  assign sw_valid = $onehot(sw_sync);

  // An invalid or empty sample clears last_valid, breaking any pending two-tick match.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      last_sw    <= '0;
      last_valid <= 1'b0;
    end else if (tick) begin
      last_sw    <= sw_sync;
      last_valid <= sw_valid;
    end
  end

  assign match  = tick && sw_valid && last_valid && (sw_sync == last_sw);
  assign accept = match && (state == S_IDLE);

  assign sum1 = {2'b00, credit} + (CW+2)'(1);
  assign sum2 = {2'b00, credit} + (CW+2)'(2);

  always_comb begin
    state_next  = state;
    credit_next = credit;
    reject_next = reject;
    disp_next   = disp_cnt;
`ifdef VEND_CHANGE_EN
    change_next = change;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next  = S_HOLD;
          reject_next = 1'b0;
          case (sw_sync)
            CMD_ADD1: begin
              if (sum1 > {2'b00, MAX_C}) begin
                credit_next = MAX_C;
                reject_next = 1'b1;
              end else begin
                credit_next = CW'(sum1);
              end
            end
            CMD_ADD2: begin
              if (sum2 > {2'b00, MAX_C}) begin
                credit_next = MAX_C;
                reject_next = 1'b1;
              end else begin
                credit_next = CW'(sum2);
              end
            end
            CMD_REFUND: begin
              if (credit == '0) begin
                reject_next = 1'b1;
              end else begin
                credit_next = credit - 1'b1;
              end
            end
            CMD_VEND: begin
              if (credit < PRICE_C) begin
                reject_next = 1'b1;
              end else begin
                state_next = S_DISPENSE;
                disp_next  = '0;
`ifdef VEND_CHANGE_EN
                change_next = 8'(credit - PRICE_C);
                credit_next = '0;
`else
                credit_next = credit - PRICE_C;
`endif
              end
            end
            CMD_CLEAR: begin
              credit_next = '0;
            end
            default: begin
              state_next = S_HOLD;
            end
          endcase
        end
      end
      S_HOLD: begin
        if (tick && (sw_sync == '0)) begin
          state_next = S_IDLE;
        end
      end
      S_DISPENSE: begin
        if (tick) begin
          if (disp_cnt == DISP_LAST) begin
            state_next = S_HOLD;
          end else begin
            disp_next = disp_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state    <= S_IDLE;
      credit   <= '0;
      reject   <= 1'b0;
      disp_cnt <= '0;
    end else begin
      state    <= state_next;
      credit   <= credit_next;
      reject   <= reject_next;
      disp_cnt <= disp_next;
    end
  end

`ifdef VEND_CHANGE_EN
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      change <= '0;
    end else begin
      change <= change_next;
    end
  end

  assign CHANGE = change;
`else
  assign CHANGE = '0;
`endif

  assign LEDR = {reject, (state == S_DISPENSE), (credit == MAX_C)};

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0001100;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [9:0] value;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;

  assign value    = 10'(credit * STEP);
  assign ones     = 4'(value % 10'd10);
  assign tens     = 4'((value / 10'd10) % 10'd10);
  assign hundreds = 4'(value / 10'd100);

  assign HEX0 = seg7(ones);
  assign HEX1 = seg7(tens);
  assign HEX3 = seg7(hundreds);

endmodule
